// File: rtl/systolic_drain.sv
// Output-side collector for the systolic array: de-skews y_stream columns into aligned rows,
// buffers them in a small FIFO and hands them downstream on a valid/ready handshake.
module systolic_drain #(
  parameter int unsigned data_size = 8,
  parameter int unsigned size      = 3,
  parameter int unsigned latency   = 3,
  parameter int unsigned depth     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                rows,
  input  logic [data_size*size-1:0] y_stream,
  output logic [data_size*size-1:0] out_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int unsigned RowW       = data_size * size;
  localparam int unsigned AddrW      = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CountW     = AddrW + 1;
  localparam int unsigned WaitCycles = latency + size - 1;
  localparam int unsigned WaitLast   = (WaitCycles >= 2) ? WaitCycles - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StDrain} state_e;

  state_e              state_q, state_d;
  logic [7:0]          rows_q, rows_d;
  logic [7:0]          cap_q, cap_d;
  logic [15:0]         wait_q, wait_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [RowW-1:0]     mem_q [depth];
  logic [RowW-1:0]     mem_d [depth];
  logic [AddrW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [RowW-1:0]     aligned_row;
  logic                push, pop, full, push_ok;

  // Column c lags column 0 by c cycles, so it is held back size-1-c stages to line up.
  for (genvar c = 0; c < size; c++) begin : g_col
    localparam int unsigned Stages = size - 1 - c;
    logic [data_size-1:0] col_in;
    assign col_in = y_stream[(size-c)*data_size-1 -: data_size];

    if (Stages == 0) begin : g_direct
      assign aligned_row[(size-c)*data_size-1 -: data_size] = col_in;
    end else begin : g_dly
      logic [data_size-1:0] dly_q [Stages];
      logic [data_size-1:0] dly_d [Stages];

      always_comb begin
        dly_d[0] = col_in;
        for (int k = 1; k < Stages; k++) dly_d[k] = dly_q[k-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < Stages; k++) dly_q[k] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign aligned_row[(size-c)*data_size-1 -: data_size] = dly_q[Stages-1];
    end
  end

  assign out_valid = (count_q != '0);
  assign out_row   = out_valid ? mem_q[rd_q] : '0;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overflow  = ovf_q;

  assign push    = (state_q == StCapture);
  assign pop     = out_valid && out_ready;
  assign full    = (count_q == CountW'(depth));
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push && (!full || pop);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cap_d   = cap_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;

    if (push && full && !pop) ovf_d = 1'b1;
    if (push_ok) begin
      mem_d[wr_q] = aligned_row;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    count_d = count_q + CountW'(push_ok) - CountW'(pop);

    case (state_q)
      StIdle: begin
        if (start) begin
          if (rows == 8'd0) begin
            done_d = 1'b1;
          end else begin
            rows_d  = rows;
            ovf_d   = 1'b0;
            cap_d   = 8'd0;
            wait_d  = 16'd0;
            state_d = (WaitCycles >= 2) ? StWait : StCapture;
          end
        end
      end
      StWait: begin
        if (wait_q == 16'(WaitLast)) state_d = StCapture;
        else                         wait_d  = wait_q + 16'd1;
      end
      StCapture: begin
        if (cap_q == rows_q - 8'd1) state_d = StDrain;
        else                        cap_d   = cap_q + 8'd1;
      end
      StDrain: begin
        if (count_d == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rows_q  <= 8'd0;
      cap_q   <= 8'd0;
      wait_q  <= 16'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cap_q   <= cap_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Randomised bench for systolic_drain against a queue-based model of batch timing and the row FIFO.
module tb_systolic_drain;
  localparam int W = 8;
  localparam int S = 3;
  localparam int L = 3;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           reset, start, out_ready;
  logic [7:0]     rows;
  logic [W*S-1:0] y_stream, out_row;
  logic           out_valid, busy, done, overflow;

  always #5 clk = ~clk;

  systolic_drain #(.data_size(W), .size(S), .latency(L), .depth(D)) dut (
    .clk(clk), .reset(reset), .start(start), .rows(rows), .y_stream(y_stream),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge index since the start edge, a queue for the FIFO, sticky flag.
  bit             m_active, m_done, m_ovf;
  int             m_n, m_rows;
  logic [W*S-1:0] q[$];
  logic [W*S-1:0] popped[$];
  logic [W-1:0]   elem [256][S];
  int             k, first_valid_k, done_k;
  int             ready_mode;

  function automatic logic [W*S-1:0] row_of(input int r);
    logic [W*S-1:0] v;
    for (int c = 0; c < S; c++) v[(S-c)*W-1 -: W] = elem[r][c];
    return v;
  endfunction

  task automatic cycle();
    int  nx, r;
    bit  pop, nd, accepted;
    nx = m_active ? m_n + 1 : -1;
    for (int c = 0; c < S; c++) begin
      r = nx - L - c;
      if (m_active && r >= 0 && r < m_rows) y_stream[(S-c)*W-1 -: W] = elem[r][c];
      else                                  y_stream[(S-c)*W-1 -: W] = 8'($urandom);
    end
    @(negedge clk);
    check_eq("valid", out_valid, q.size() > 0);
    if (q.size() > 0) check_eq("row", out_row, q[0]);
    check_eq("busy", busy, m_active);
    check_eq("done", done, m_done);
    check_eq("overflow", overflow, m_ovf);
    if (out_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
    if (done === 1'b1) done_k = k;
    @(posedge clk);
    accepted = 1'b0;
    if (reset) begin
      q.delete();
      m_active = 0; m_done = 0; m_ovf = 0;
    end else begin
      pop = (q.size() > 0) && out_ready;
      nd  = 0;
      if (pop) popped.push_back(q.pop_front());
      if (m_active) begin
        m_n++;
        r = m_n - (L + S - 1);
        if (r >= 0 && r < m_rows) begin
          if (q.size() < D) q.push_back(row_of(r));
          else              m_ovf = 1;
        end else if (r >= m_rows && q.size() == 0) begin
          nd = 1;
          m_active = 0;
        end
      end else if (start) begin
        if (rows == 8'd0) nd = 1;
        else begin
          m_active = 1; m_n = 0; m_rows = int'(rows); m_ovf = 0; accepted = 1;
        end
      end
      m_done = nd;
    end
    k = accepted ? 0 : k + 1;
    #1;
    start = 1'b0;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = !(m_active && (m_n + 1) <= (L + S - 2 + m_rows));
      2: out_ready = (k >= 5) ? ((k - 5) % 2 == 1) : 1'b0;
      default: out_ready = ($urandom % 4) != 0;
    endcase
  endtask

  task automatic start_batch(input int n);
    rows = 8'(n);
    start = 1'b1;
    first_valid_k = -1;
    done_k = -1;
    popped.delete();
    cycle();
  endtask

  task automatic run_until_idle(input int budget);
    int i;
    i = 0;
    do begin
      cycle();
      i++;
    end while ((m_active || m_done) && i < budget);
    if (m_active || m_done) check_eq("timeout", 1, 0);
  endtask

  task automatic fill_nominal();
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < S; c++) elem[r][c] = 8'(10 * r + c + 1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < S; c++) elem[r][c] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rows = 8'd0; out_ready = 1'b1; y_stream = '0;
    m_active = 0; m_done = 0; m_ovf = 0; m_n = 0; m_rows = 0; k = 0;
    first_valid_k = -1; done_k = -1; ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    check_eq("rst_row", out_row, 0);
    reset = 1'b0;
    cycle();

    // Nominal batch; cycles counted from 1 at the start edge.
    fill_nominal();
    ready_mode = 0;
    start_batch(3);
    run_until_idle(100);
    check_eq("nom_first_valid_cycle", first_valid_k + 1, 6);
    check_eq("nom_done_cycle", done_k + 1, 9);
    check_eq("nom_count", popped.size(), 3);
    if (popped.size() == 3) begin
      check_eq("nom_row0", popped[0], 24'h010203);
      check_eq("nom_row1", popped[1], 24'h0b0c0d);
      check_eq("nom_row2", popped[2], 24'h151617);
    end
    check_eq("nom_busy_after", busy, 0);
    repeat (2) cycle();

    // Backpressure: rows 4 and 5 dropped, four pop in order afterwards.
    fill_random();
    ready_mode = 1;
    start_batch(6);
    run_until_idle(200);
    check_eq("ovf_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) check_eq("ovf_order", popped[i], row_of(i));
    check_eq("ovf_sticky", overflow, 1);
    ready_mode = 0;
    repeat (3) cycle();
    check_eq("ovf_still_set", overflow, 1);

    // Toggling ready; rows=7 reaches a full FIFO on the same edge as a pop.
    fill_random();
    ready_mode = 2;
    start_batch(5);
    run_until_idle(200);
    start_batch(7);
    run_until_idle(200);
    check_eq("stall_count", popped.size(), 7);
    check_eq("stall_no_ovf", overflow, 0);

    // rows=0: done one cycle later, nothing presented.
    ready_mode = 0;
    start_batch(0);
    check_eq("zero_done", done, 1);
    check_eq("zero_valid", out_valid, 0);
    repeat (3) cycle();

    // A second start during capture is ignored.
    fill_random();
    start_batch(4);
    while (k < 5) cycle();
    rows = 8'd9;
    start = 1'b1;
    cycle();
    run_until_idle(200);
    check_eq("busy_start_count", popped.size(), 4);

    // Reset mid-batch, then a fresh nominal batch.
    fill_nominal();
    start_batch(3);
    while (k < 6) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("midrst_row", out_row, 0);
    check_eq("midrst_valid", out_valid, 0);
    repeat (4) cycle();
    check_eq("midrst_no_done", done_k, -1);
    start_batch(3);
    run_until_idle(100);
    check_eq("rerun_count", popped.size(), 3);
    if (popped.size() == 3) check_eq("rerun_row2", popped[2], 24'h151617);
    check_eq("rerun_done_cycle", done_k + 1, 9);

    // Random batches with random ready and stray start pulses.
    ready_mode = 3;
    for (int b = 0; b < 8; b++) begin
      fill_random();
      start_batch($urandom_range(1, 12));
      for (int i = 0; i < 400 && (m_active || m_done); i++) begin
        if ($urandom % 8 == 0) begin
          rows = 8'($urandom);
          start = 1'b1;
        end
        cycle();
      end
      if (m_active || m_done) check_eq("rand_timeout", 1, 0);
      repeat ($urandom_range(0, 3)) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side collector for the systolic array: the counterpart of the input/weight feeder that drives data_stream/w_stream.
- Samples the array's skewed y_stream, where column c of result row r appears c cycles after column 0.
- Delays each column so that all columns of a result row line up, and buffers aligned rows in a small FIFO.
- Presents rows downstream on a valid/ready handshake, with batch start/done control and overflow flagging.

Parameters:
- data_size, 8, bit width of one result element.
- size, 3, array dimension; number of columns in y_stream.
- latency, 3, cycles from the start-sampled cycle to the cycle column 0 of row 0 is valid on y_stream.
- depth, 4, row FIFO depth in entries; must be a power of two, 2 or greater.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; the cycle the first data row enters the array.
- rows  in  8  number of result rows in the batch; sampled with start.
- y_stream  in  data_size*size  array output; column c at bits [(size-c)*data_size-1 -: data_size].
- out_row  out  data_size*size  aligned result row; same column packing as y_stream.
- out_valid  out  1  out_row holds a valid row.
- out_ready  in  1  downstream accepts a row when out_valid and out_ready are both high.
- busy  out  1  high from the start-accepted cycle until done.
- done  out  1  one-cycle pulse when a batch completes.
- overflow  out  1  sticky; a completed row was dropped because the FIFO was full.

Behaviour:
- Reset:
  - Outputs: out_row=0, out_valid=0, busy=0, done=0, overflow=0.
  - FIFO emptied, all delay lines and counters zeroed, state IDLE.
  - Reset asserted mid-batch aborts the batch immediately; there is no done pulse.
- Timing reference: n=0 is the clock edge where start=1 is sampled in IDLE.
  - Element (r,c) is sampled from y_stream at edge n = latency + r + c.
- De-skew:
  - Column c passes through a (size-1-c)-stage register delay.
  - Column size-1 is taken directly.
  - Aligned row r is complete at edge n = latency + r + size - 1 and is pushed into the FIFO on that edge.
- States:
  - IDLE: busy=0.
    - start=1 with rows=0: pulse done on the next cycle, stay IDLE.
    - start=1 with rows>0: latch rows, clear overflow, go to WAIT.
  - WAIT: counts latency+size-1 cycles, then goes to CAPTURE.
  - CAPTURE: pushes one aligned row per cycle for `rows` cycles, then goes to DRAIN.
  - DRAIN: when the FIFO is empty (last pop done), pulse done for one cycle and go to IDLE.
- start is ignored outside IDLE. busy is high in WAIT, CAPTURE and DRAIN.
- FIFO:
  - depth entries, registered output; out_valid reflects FIFO not empty.
  - A row pushed into an empty FIFO appears on out_row/out_valid the cycle after the push edge.
  - Push and pop in the same cycle when full: the pop frees the slot and the push succeeds, with no overflow.
  - Push when full and no pop: the row is dropped and overflow is set. Capture timing is not stalled, because the array has no backpressure.
  - out_row holds stable while out_valid=1 and out_ready=0.
- Arithmetic: no arithmetic on data; elements pass through unmodified at data_size bits. The row counter is 8 bits; rows=255 is legal.

Test Plan:
- Nominal batch:
  - Stimulus: size=3, latency=3, rows=3; element (r,c) = 10r+c+1 driven at edge 3+r+c; out_ready held 1.
  - Required: rows {1,2,3}, {11,12,13}, {21,22,23} on out_row with out_valid at cycles 6, 7 and 8.
  - Required: done pulse at cycle 9; busy=0 afterwards.
- Backpressure/overflow:
  - Stimulus: rows=6, out_ready=0 throughout capture.
  - Required: rows 0-3 stored, rows 4-5 dropped, overflow=1.
  - Stimulus: then raise out_ready.
  - Required: exactly 4 rows pop in order, then done; overflow stays 1 until the next start.
- Stall with full FIFO and simultaneous pop:
  - Stimulus: rows=5, out_ready toggling 0/1 every cycle from cycle 6.
  - Required: out_row stable while not accepted; overflow=0 whenever a pop coincides with a full-FIFO push.
- rows=0 and start-while-busy:
  - Stimulus: start with rows=0.
  - Required: done pulses one cycle later, no out_valid.
  - Stimulus: a second start during CAPTURE.
  - Required: ignored; row count unchanged.
- Reset mid-batch:
  - Stimulus: assert reset at cycle 7 of the nominal batch.
  - Required: next cycle all outputs are 0, FIFO empty, no done pulse.
  - Stimulus: a fresh start.
  - Required: the nominal result is reproduced.
